// File: rtl/melody_sequencer.sv
// melody_sequencer
//   Plays a melody by stepping a note index through an external combinational
//   note ROM and turning each divider value into a square-wave tone. Every
//   note lasts STEP_CYCLES clocks, and the last GAP_CYCLES of each step are
//   silent so that repeated notes stay articulated. Playback can be started,
//   stopped and paused, and it either ends after one pass or loops.
//
// Ports
//   clk_i            system clock
//   rst_i            synchronous reset, active-high
//   start_i          pulse: (re)start playback at note 0
//   stop_i           pulse: abort playback and go idle
//   pause_i          level: freeze step and tone counters; output is silent
//   loop_i           level: sampled at the end of the last step, 1 = wrap to note 0
//   divider_value_i  ROM data for note_index_o (tone half-period, 0 = rest)
//   note_index_o     current ROM address (registered)
//   tone_o           square-wave audio output (registered)
//   busy_o           1 while playing
//   done_o           1-cycle pulse when a one-shot pass ends naturally
module melody_sequencer #(
    parameter int BW          = 16,
    parameter int NOTES       = 64,
    parameter int IDX_W       = 6,
    parameter int STEP_CYCLES = 1500000,
    parameter int GAP_CYCLES  = 150000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             pause_i,
    input  logic             loop_i,
    input  logic [BW-1:0]    divider_value_i,
    output logic [IDX_W-1:0] note_index_o,
    output logic             tone_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int SC_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    localparam logic [SC_W-1:0]  STEP_LAST   = SC_W'(STEP_CYCLES - 1);
    // One bit wider so that GAP_CYCLES = 0 with a power-of-two step length
    // does not truncate the audible limit to zero.
    localparam logic [SC_W:0]    AUDIBLE_END = (SC_W + 1)'(STEP_CYCLES - GAP_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NOTES - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [SC_W-1:0]  step_cnt_q;
    logic [BW-1:0]    tone_cnt_q;
    logic [BW-1:0]    div_q;
    logic             tone_q;
    logic             tone_o_q;
    logic             done_q;

    logic             step_wrap_s;
    logic             last_note_s;
    logic             tone_hit_s;
    logic             tone_o_d;

    // Decode step/tone boundaries and the next audible output level.
    always_comb begin
        step_wrap_s = (step_cnt_q == STEP_LAST);
        last_note_s = (idx_q == IDX_LAST);
        if (div_q != {BW{1'b0}}) begin
            tone_hit_s = (tone_cnt_q == (div_q - {{(BW-1){1'b0}}, 1'b1}));
        end else begin
            tone_hit_s = 1'b0;
        end
        // The square wave is audible only while playing, unpaused, not a rest
        // and before the articulation gap; stop silences it at once.
        tone_o_d = tone_q
                 && (div_q != {BW{1'b0}})
                 && ({1'b0, step_cnt_q} < AUDIBLE_END)
                 && !pause_i
                 && !stop_i
                 && (state_q == ST_PLAY);
    end

    // Playback FSM with step counter, tone generator and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            idx_q      <= {IDX_W{1'b0}};
            step_cnt_q <= {SC_W{1'b0}};
            tone_cnt_q <= {BW{1'b0}};
            div_q      <= {BW{1'b0}};
            tone_q     <= 1'b0;
            tone_o_q   <= 1'b0;
            done_q     <= 1'b0;
        end else if (stop_i) begin
            state_q    <= ST_IDLE;
            idx_q      <= {IDX_W{1'b0}};
            step_cnt_q <= {SC_W{1'b0}};
            tone_cnt_q <= {BW{1'b0}};
            div_q      <= {BW{1'b0}};
            tone_q     <= 1'b0;
            tone_o_q   <= 1'b0;
            done_q     <= 1'b0;
        end else if (start_i) begin
            // Restart looks exactly like a fresh start from idle; the first
            // step cycle then loads the divider for note 0.
            state_q    <= ST_PLAY;
            idx_q      <= {IDX_W{1'b0}};
            step_cnt_q <= {SC_W{1'b0}};
            tone_cnt_q <= {BW{1'b0}};
            div_q      <= {BW{1'b0}};
            tone_q     <= 1'b0;
            tone_o_q   <= tone_o_d;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tone_o_q <= 1'b0;
                    done_q   <= 1'b0;
                end
                ST_PLAY: begin
                    tone_o_q <= tone_o_d;
                    done_q   <= 1'b0;
                    if (!pause_i) begin
                        // Tone generator: reload at the start of every step,
                        // otherwise count half-periods of the current note.
                        if (step_cnt_q == {SC_W{1'b0}}) begin
                            div_q      <= divider_value_i;
                            tone_cnt_q <= {BW{1'b0}};
                            tone_q     <= 1'b0;
                        end else if (div_q != {BW{1'b0}}) begin
                            if (tone_hit_s) begin
                                tone_cnt_q <= {BW{1'b0}};
                                tone_q     <= ~tone_q;
                            end else begin
                                tone_cnt_q <= tone_cnt_q + {{(BW-1){1'b0}}, 1'b1};
                            end
                        end else begin
                            tone_cnt_q <= {BW{1'b0}};
                        end

                        // Step sequencing; the end of the last step either
                        // wraps (loop) or finishes the pass.
                        if (step_wrap_s) begin
                            step_cnt_q <= {SC_W{1'b0}};
                            if (last_note_s) begin
                                idx_q <= {IDX_W{1'b0}};
                                if (!loop_i) begin
                                    state_q    <= ST_IDLE;
                                    div_q      <= {BW{1'b0}};
                                    tone_cnt_q <= {BW{1'b0}};
                                    tone_q     <= 1'b0;
                                    done_q     <= 1'b1;
                                end
                            end else begin
                                idx_q <= idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                            end
                        end else begin
                            step_cnt_q <= step_cnt_q + {{(SC_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    idx_q      <= {IDX_W{1'b0}};
                    step_cnt_q <= {SC_W{1'b0}};
                    tone_cnt_q <= {BW{1'b0}};
                    div_q      <= {BW{1'b0}};
                    tone_q     <= 1'b0;
                    tone_o_q   <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign note_index_o = idx_q;
    assign tone_o       = tone_o_q;
    assign busy_o       = (state_q == ST_PLAY);
    assign done_o       = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench for melody_sequencer: a behavioural playback model
// predicts every output cycle and pushes the prediction into a scoreboard
// queue; an independent monitor pops and compares one entry per clock.
module tb_melody_sequencer;

    localparam int BW    = 16;
    localparam int NOTES = 4;
    localparam int IDX_W = 2;
    localparam int STEP  = 20;
    localparam int GAP   = 4;

    logic             clk     = 1'b0;
    logic             rst_i   = 1'b1;
    logic             start_i = 1'b0;
    logic             stop_i  = 1'b0;
    logic             pause_i = 1'b0;
    logic             loop_i  = 1'b0;
    logic [BW-1:0]    div_s;
    logic [IDX_W-1:0] note_index_o;
    logic             tone_o;
    logic             busy_o;
    logic             done_o;

    logic [BW-1:0]    rom [NOTES];

    assign div_s = rom[note_index_o];

    always #5 clk = ~clk;

    melody_sequencer #(
        .BW          (BW),
        .NOTES       (NOTES),
        .IDX_W       (IDX_W),
        .STEP_CYCLES (STEP),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .stop_i          (stop_i),
        .pause_i         (pause_i),
        .loop_i          (loop_i),
        .divider_value_i (div_s),
        .note_index_o    (note_index_o),
        .tone_o          (tone_o),
        .busy_o          (busy_o),
        .done_o          (done_o)
    );

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             tone;
        logic             busy;
        logic             done;
    } exp_t;

    exp_t  sb_q[$];
    int    checks   = 0;
    int    failures = 0;

    // Window checks: stimulus opens a window, monitor counts busy/done samples.
    bit    win_open     = 1'b0;
    int    win_busy_exp = 0;
    int    win_done_exp = 0;
    string win_name     = "none";

    // Behavioural model state: playing flag, note, position in step,
    // divider of the sounding note and cycles elapsed since it was loaded.
    bit m_play = 1'b0;
    int m_idx  = 0;
    int m_pos  = 0;
    int m_div  = 0;
    int m_k    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, predict the outputs after the next edge.
    task automatic cyc(input bit rst, input bit stp, input bit sta, input bit pau, input bit lp);
        exp_t e;
        bit   tone;
        rst_i   = rst;
        stop_i  = stp;
        start_i = sta;
        pause_i = pau;
        loop_i  = lp;
        // Tone is the square wave of the loaded divider, half-period m_div,
        // audible outside the gap and only while playing unpaused.
        tone = !rst && !stp && m_play && !pau && (m_div != 0)
             && (m_pos < STEP - GAP) && (((m_k / ((m_div != 0) ? m_div : 1)) % 2) == 1);
        e.done = 1'b0;
        if (rst || stp) begin
            m_play = 1'b0; m_idx = 0; m_pos = 0; m_div = 0; m_k = 0;
        end else if (sta) begin
            m_play = 1'b1; m_idx = 0; m_pos = 0; m_div = 0; m_k = 0;
        end else if (m_play && !pau) begin
            if (m_pos == 0) begin
                m_div = int'(rom[m_idx]);
                m_k   = 0;
            end else begin
                m_k++;
            end
            if (m_pos == STEP - 1) begin
                m_pos = 0;
                if (m_idx == NOTES - 1) begin
                    m_idx = 0;
                    if (!lp) begin
                        m_play = 1'b0; m_div = 0; m_k = 0;
                        e.done = 1'b1;
                    end
                end else begin
                    m_idx++;
                end
            end else begin
                m_pos++;
            end
        end
        e.idx  = IDX_W'(m_idx);
        e.tone = tone;
        e.busy = m_play;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run(input int n, input bit pau, input bit lp);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, pau, lp);
    endtask

    // Monitor: one scoreboard entry per clock, sampled 1 time unit after the edge.
    initial begin : monitor
        exp_t e;
        int   wb;
        int   wd;
        bit   was_open;
        wb = 0; wd = 0; was_open = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("note_index", 32'(note_index_o), 32'(e.idx));
                chk("tone", 32'(tone_o), 32'(e.tone));
                chk("busy", 32'(busy_o), 32'(e.busy));
                chk("done", 32'(done_o), 32'(e.done));
            end
            if (win_open) begin
                if (!was_open) begin
                    wb = 0;
                    wd = 0;
                end
                wb += int'(busy_o);
                wd += int'(done_o);
            end else if (was_open) begin
                chk({win_name, "_busy_cycles"}, 32'(wb), 32'(win_busy_exp));
                chk({win_name, "_done_pulses"}, 32'(wd), 32'(win_done_exp));
            end
            was_open = win_open;
        end
    end

    // Stimulus: directed scenarios followed by randomized traffic.
    initial begin : stimulus
        bit pau;
        bit lp;
        int r;
        rom[0] = 16'd3; rom[1] = 16'd0; rom[2] = 16'd5; rom[3] = 16'd2;
        @(negedge clk);
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run(2, 1'b0, 1'b0);

        // One-shot pass: 4 steps of 20 cycles, then a single done pulse.
        win_name = "oneshot"; win_busy_exp = 80; win_done_exp = 1; win_open = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run(90, 1'b0, 1'b0);
        win_open = 1'b0;
        run(2, 1'b0, 1'b0);

        // Looping: three full passes without done, busy held.
        win_name = "loop"; win_busy_exp = 246; win_done_exp = 0; win_open = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        run(245, 1'b0, 1'b1);
        win_open = 1'b0;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        run(5, 1'b0, 1'b0);

        // Pause 7 cycles in step 2: pass stretches from 80 to 87 busy cycles.
        win_name = "pause"; win_busy_exp = 87; win_done_exp = 1; win_open = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run(45, 1'b0, 1'b0);
        run(7, 1'b1, 1'b0);
        run(40, 1'b0, 1'b0);
        win_open = 1'b0;
        run(2, 1'b0, 1'b0);

        // Stop during note 1.
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run(25, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run(5, 1'b0, 1'b0);

        // Stop and start together: stop wins, both from PLAY and from IDLE.
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run(10, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        run(3, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        run(3, 1'b0, 1'b0);

        // Restart during note 2, with pause held on the restart cycle.
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run(45, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        run(30, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset mid-play while looping.
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        run(30, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        run(5, 1'b0, 1'b0);

        // Randomized traffic with random ROM contents.
        for (int pass = 0; pass < 4; pass++) begin
            for (int i = 0; i < NOTES; i++) begin
                if ($urandom_range(0, 5) == 0) rom[i] = 16'd25;
                else rom[i] = BW'($urandom_range(0, 9));
            end
            pau = 1'b0;
            lp  = 1'($urandom_range(0, 1));
            cyc(1'b1, 1'b0, 1'b0, 1'b0, lp);
            cyc(1'b0, 1'b0, 1'b1, 1'b0, lp);
            for (int c = 0; c < 700; c++) begin
                r = int'($urandom_range(0, 999));
                if ($urandom_range(0, 29) == 0) pau = ~pau;
                if ($urandom_range(0, 99) == 0) lp = ~lp;
                cyc((r < 2), (r >= 2 && r < 6), (r >= 6 && r < 16), pau, lp);
            end
        end

        run(4, 1'b0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
